e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the P7 pipeline. It produces the `E_MDU_Start` and `E_MDU_Busy` signals that the hazard unit uses to stall MDU-class instructions in D. It holds the HI/LO registers and runs multi-cycle mult/div operations. It also serves mfhi/mflo reads and mthi/mtlo writes. An exception or interrupt request from the CP0 side cancels any MDU side effect of the instruction currently in E.

---
 rtl/e_mdu_pkg.sv | 28 ++
 rtl/e_mdu_if.sv | 24 ++
 rtl/e_mdu_arith.sv | 67 ++++++
 rtl/e_mdu.sv | 105 ++++++++++
 tb/tb_e_mdu.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/e_mdu_pkg.sv
// E_MDU shared definitions: MDU op codes, default latencies, op helpers.
package e_mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E_MDU bus: E-stage op/operands in, start/busy and HI/LO results out.
interface e_mdu_if;

   logic        Req;
   logic [3:0]  MDU_Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDU_Out;

   modport master (
      output Req, MDU_Op, A, B,
      input  Start, Busy, HI, LO, MDU_Out
   );

   modport slave (
      input  Req, MDU_Op, A, B,
      output Start, Busy, HI, LO, MDU_Out
   );

endinterface

// File: rtl/e_mdu_arith.sv
// MDU_ARITH: combinational mult/div result for the latched op and operands.
module e_mdu_arith
   import e_mdu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_wr_en
);

   logic signed [63:0] w_smul;
   logic        [63:0] w_umul;
   logic               w_b_zero;
   logic               w_ovf;
   logic        [31:0] w_sdiv_b;
   logic        [31:0] w_udiv_b;
   logic        [31:0] w_sq;
   logic        [31:0] w_sr;
   logic        [31:0] w_uq;
   logic        [31:0] w_ur;

   assign w_smul = $signed({{32{i_a[31]}}, i_a}) *
                   $signed({{32{i_b[31]}}, i_b});
   assign w_umul = {32'd0, i_a} * {32'd0, i_b};

   assign w_b_zero = (i_b == 32'd0);
   assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

   // Divisor forced to 1 for /0 and MIN/-1: the latter then yields a/1, r=0
   assign w_sdiv_b = (w_b_zero || w_ovf) ? 32'd1 : i_b;
   assign w_udiv_b = w_b_zero ? 32'd1 : i_b;

   assign w_sq = $signed(i_a) / $signed(w_sdiv_b);
   assign w_sr = $signed(i_a) % $signed(w_sdiv_b);
   assign w_uq = i_a / w_udiv_b;
   assign w_ur = i_a % w_udiv_b;

   always_comb begin
      o_hi    = 32'd0;
      o_lo    = 32'd0;
      o_wr_en = 1'b0;
      case (i_op)
         MDU_MULT: begin
            {o_hi, o_lo} = w_smul;
            o_wr_en      = 1'b1;
         end
         MDU_MULTU: begin
            {o_hi, o_lo} = w_umul;
            o_wr_en      = 1'b1;
         end
         MDU_DIV: begin
            o_hi    = w_sr;
            o_lo    = w_sq;
            o_wr_en = ~w_b_zero;
         end
         MDU_DIVU: begin
            o_hi    = w_ur;
            o_lo    = w_uq;
            o_wr_en = ~w_b_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// E_MDU: E-stage multiply/divide unit holding HI/LO with a multi-cycle
// busy window used by the hazard unit to stall MDU ops in D.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   e_mdu_if.slave bus
);

   localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e      r_state;
   logic [CW-1:0] r_cnt;
   logic        r_busy;
   logic [3:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_start;
   logic [31:0] w_hi_next;
   logic [31:0] w_lo_next;
   logic        w_wr_en;

   assign w_start = is_muldiv(bus.MDU_Op) & ~bus.Req & ~r_busy;

   e_mdu_arith u_arith (
      .i_op    (r_op),
      .i_a     (r_a),
      .i_b     (r_b),
      .o_hi    (w_hi_next),
      .o_lo    (w_lo_next),
      .o_wr_en (w_wr_en)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_op    <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_op    <= bus.MDU_Op;
                  r_a     <= bus.A;
                  r_b     <= bus.B;
                  r_cnt   <= is_div(bus.MDU_Op) ? CW'(DIV_CYCLES - 1)
                                                : CW'(MULT_CYCLES - 1);
               end else if (!bus.Req) begin
                  if (bus.MDU_Op == MDU_MTHI) r_hi <= bus.A;
                  if (bus.MDU_Op == MDU_MTLO) r_lo <= bus.A;
               end
            end
            S_RUN: begin
               // A running op commits regardless of Req
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  if (w_wr_en) begin
                     r_hi <= w_hi_next;
                     r_lo <= w_lo_next;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.MDU_Out = 32'd0;
      case (bus.MDU_Op)
         MDU_MFHI: bus.MDU_Out = r_hi;
         MDU_MFLO: bus.MDU_Out = r_lo;
         default:  ;
      endcase
   end

   assign bus.Start = w_start;
   assign bus.Busy  = r_busy;
   assign bus.HI    = r_hi;
   assign bus.LO    = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: arithmetic reference model compared
// every cycle, plus hand-computed literal expectations.
module tb_e_mdu;
   import e_mdu_pkg::*;

   localparam int NM = 5;
   localparam int ND = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   e_mdu_if bus ();

   e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", nm, act, exp);
      end
   endtask

   // Reference model: remaining busy cycles and architectural HI/LO
   int          m_left = 0;
   logic [31:0] m_hi = 0, m_lo = 0;
   logic [31:0] p_hi = 0, p_lo = 0;
   bit          p_wr = 0;
   bit          chk_en = 0;

   function automatic bit exp_start();
      int op;
      op = int'(bus.MDU_Op);
      return (op >= 1) && (op <= 4) && !bus.Req && (m_left == 0);
   endfunction

   always @(posedge clk) begin : model
      longint sa, sb, q, r;
      logic [63:0] prod;
      if (!reset) begin
         m_left = 0; m_hi = 0; m_lo = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && p_wr) begin
            m_hi = p_hi; m_lo = p_lo;
         end
      end else if (exp_start()) begin
         p_wr = 1;
         case (int'(bus.MDU_Op))
            1: begin
               sa = longint'($signed(bus.A));
               sb = longint'($signed(bus.B));
               prod = 64'(sa * sb);
               {p_hi, p_lo} = prod;
               m_left = NM;
            end
            2: begin
               prod = 64'(bus.A) * 64'(bus.B);
               {p_hi, p_lo} = prod;
               m_left = NM;
            end
            3: begin
               sa = longint'($signed(bus.A));
               sb = longint'($signed(bus.B));
               if (sb == 0) p_wr = 0;
               else begin
                  q = sa / sb; r = sa - q * sb;
                  p_lo = q[31:0]; p_hi = r[31:0];
               end
               m_left = ND;
            end
            default: begin
               sa = longint'({32'd0, bus.A});
               sb = longint'({32'd0, bus.B});
               if (sb == 0) p_wr = 0;
               else begin
                  q = sa / sb; r = sa - q * sb;
                  p_lo = q[31:0]; p_hi = r[31:0];
               end
               m_left = ND;
            end
         endcase
      end else if (!bus.Req) begin
         if (bus.MDU_Op == 4'd7) m_hi = bus.A;
         if (bus.MDU_Op == 4'd8) m_lo = bus.A;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] eo;
      if (chk_en) begin
         eo = (bus.MDU_Op == 4'd5) ? m_hi :
              (bus.MDU_Op == 4'd6) ? m_lo : 32'd0;
         check("m_busy",  32'(bus.Busy),  32'(m_left > 0));
         check("m_start", 32'(bus.Start), 32'(exp_start()));
         check("m_hi",    bus.HI, m_hi);
         check("m_lo",    bus.LO, m_lo);
         check("m_out",   bus.MDU_Out, eo);
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rq);
      @(posedge clk); #1;
      bus.MDU_Op = op; bus.A = a; bus.B = b; bus.Req = rq;
   endtask

   task automatic wait_idle(input string nm, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.Busy) break;
         n++;
      end
      if (n >= 40) check({nm, "_timeout"}, 32'(n), 32'd0);
   endtask

   task automatic run_op(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_n);
      int n;
      drive(op, a, b, 1'b0);
      @(negedge clk);
      check({nm, "_start"}, 32'(bus.Start), 32'd1);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      wait_idle(nm, n);
      check({nm, "_ncyc"}, 32'(n), 32'(exp_n));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      reset = 1'b0;
      bus.Req = 1'b0; bus.MDU_Op = 4'd0; bus.A = 0; bus.B = 0;
      @(posedge clk); #1 chk_en = 1;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_hi", bus.HI, 32'd0);
      check("rst_lo", bus.LO, 32'd0);

      run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, NM);
      check("mult_hi", bus.HI, 32'hFFFF_FFFF);
      check("mult_lo", bus.LO, 32'hFFFF_FFF1);

      run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, NM);
      check("multu_hi", bus.HI, 32'h0000_0001);
      check("multu_lo", bus.LO, 32'hFFFF_FFFE);

      run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, ND);
      check("div_lo", bus.LO, 32'hFFFF_FFFD);
      check("div_hi", bus.HI, 32'hFFFF_FFFF);

      run_op("divu0", MDU_DIVU, 32'd7, 32'd0, ND);
      check("divu0_hi", bus.HI, 32'hFFFF_FFFF);
      check("divu0_lo", bus.LO, 32'hFFFF_FFFD);

      run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ND);
      check("divovf_lo", bus.LO, 32'h8000_0000);
      check("divovf_hi", bus.HI, 32'd0);

      run_op("divu", MDU_DIVU, 32'd100, 32'd7, ND);
      check("divu_lo", bus.LO, 32'd14);
      check("divu_hi", bus.HI, 32'd2);

      drive(MDU_DIV, 32'd9, 32'd2, 1'b1);
      @(negedge clk);
      check("req_start", 32'(bus.Start), 32'd0);
      drive(MDU_MTHI, 32'h1234, 32'd0, 1'b1);
      @(negedge clk);
      check("req_busy", 32'(bus.Busy), 32'd0);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("req_hi", bus.HI, 32'd2);
      check("req_lo", bus.LO, 32'd14);

      drive(MDU_MTHI, 32'h55, 32'd0, 1'b0);
      drive(MDU_MFHI, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("mfhi_out", bus.MDU_Out, 32'h55);
      drive(MDU_MTLO, 32'hABCD, 32'd0, 1'b0);
      drive(MDU_MFLO, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("mflo_out", bus.MDU_Out, 32'h0000_ABCD);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("none_out", bus.MDU_Out, 32'd0);
      drive(4'd12, 32'd3, 32'd3, 1'b0);
      @(negedge clk);
      check("op12_out", bus.MDU_Out, 32'd0);
      check("op12_start", 32'(bus.Start), 32'd0);

      drive(MDU_MULT, 32'd3, 32'd4, 1'b0);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      repeat (NM) @(negedge clk);
      drive(MDU_MULT, 32'd5, 32'd6, 1'b0);
      @(negedge clk);
      check("b2b_start", 32'(bus.Start), 32'd1);
      check("b2b_lo1", bus.LO, 32'd12);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      wait_idle("b2b", n);
      check("b2b_ncyc", 32'(n), 32'(NM));
      check("b2b_lo2", bus.LO, 32'd30);

      drive(MDU_MULT, 32'd2, 32'd2, 1'b0);
      drive(MDU_MULTU, 32'd7, 32'd7, 1'b0);
      @(negedge clk);
      check("busy_start", 32'(bus.Start), 32'd0);
      drive(MDU_MTHI, 32'hDEAD, 32'd0, 1'b0);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      wait_idle("busyign", n);
      check("busyign_lo", bus.LO, 32'd4);
      check("busyign_hi", bus.HI, 32'd0);

      drive(MDU_DIV, 32'd100, 32'd3, 1'b0);
      drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("mid_busy", 32'(bus.Busy), 32'd0);
      check("mid_hi", bus.HI, 32'd0);
      check("mid_lo", bus.LO, 32'd0);

      run_op("post", MDU_MULT, 32'd2, 32'd3, NM);
      check("post_lo", bus.LO, 32'd6);
      check("post_hi", bus.HI, 32'd0);

      repeat (2) @(negedge clk);
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
